traffic_light_ctrl: RTL and testbench
=====================================

Name: traffic_light_ctrl

Overview:
- Intersection sequencing FSM for a main road and a side road, with a pedestrian walk phase on the side-road green.
- Sits directly upstream of the 1 Hz phase timer. It loads the timer's 4-bit `value` and pulses `start_timer`.
- It consumes the timer's `expired` level and advances the phase on each expiry.
- Drives the lamp outputs for both roads and the walk lamp.

Parameters:
- T_MAIN, default 4'd10: main green duration in seconds. Legal range 1..15.
- T_SIDE, default 4'd6: side green base duration in seconds. Legal range 1..15.
- T_EXT, default 4'd3: side green extension duration in seconds. Legal range 1..15.
- MAX_EXT, default 2: maximum number of side green extensions per cycle. Legal range 0..3.
- T_YEL, default 4'd3: yellow duration in seconds. Legal range 1..15.
- T_ALLRED, default 4'd1: all-red clearance duration in seconds. Legal range 1..15.

Ports:
- clk  input  1  system clock.
- Reset  input  1  asynchronous, active-low reset. Asserting it (0) clears all state immediately; release is sampled on clk.
- expired  input  1  timer expiry level from the phase timer. May be asynchronous to clk.
- sensor  input  1  side-road vehicle present, level.
- walk_req  input  1  pedestrian button. Any high sample sets the walk latch.
- value  output  4  duration loaded into the phase timer.
- start_timer  output  1  one-clk pulse that starts the phase timer.
- main_light  output  3  main-road lamp, {R,Y,G}.
- side_light  output  3  side-road lamp, {R,Y,G}.
- walk  output  1  walk lamp.

Behaviour:
- Lamp encoding: RED=3'b100, YEL=3'b010, GRN=3'b001. Exactly one bit is set at all times.
- Reset asserted (Reset=0), at any time, including mid-phase:
  - state=S_INIT; main_light=RED; side_light=RED; walk=0.
  - start_timer=0; value=4'd0; walk latch=0; ext_cnt=0; synchroniser and edge flops=0.
- States, with lamps and entry duration:
  - S_INIT: both RED, no timer. First clk after Reset release goes to S_AR2.
  - S_MG: main GRN, side RED, duration T_MAIN.
  - S_MY: main YEL, side RED, duration T_YEL.
  - S_AR1: both RED, duration T_ALLRED.
  - S_SG: main RED, side GRN, duration T_SIDE; extensions use T_EXT.
  - S_SY: main RED, side YEL, duration T_YEL.
  - S_AR2: both RED, duration T_ALLRED.
- Transitions, taken only on an expiry event `exp_ev`:
  - S_MG: if sensor=1 or walk latch=1, go to S_MY. Otherwise restart S_MG with T_MAIN (a new start_timer pulse, state unchanged).
  - S_MY goes to S_AR1; S_AR1 goes to S_SG.
  - S_SG: if sensor=1 and ext_cnt<MAX_EXT, restart with T_EXT and increment ext_cnt. Otherwise go to S_SY.
  - S_SY goes to S_AR2; S_AR2 goes to S_MG.
- ext_cnt clears on entry to S_SG.
- Timer handshake:
  - Every state entry or restart registers value<=duration and start_timer<=1 in the same clk edge.
  - start_timer is high for exactly the first clk of the phase, then 0.
  - value holds stable until the next entry or restart.
- Expiry detection:
  - expired passes through a 2-flop synchroniser, then a rising-edge detect, producing `exp_ev`.
  - exp_ev is honoured only while an `armed` flag is set.
  - armed sets on start_timer and clears on the exp_ev it consumes.
  - Latency: the transition occurs on the 3rd clk edge after expired rises.
  - exp_ev while not armed, or in S_INIT, is ignored.
  - expired held high never produces a second event.
- Walk:
  - The walk latch sets on any clk with walk_req=1, from any state except S_INIT.
  - On entry to S_SG, walk<=latch and the latch clears. This is simultaneous with the S_SG entry edge.
  - walk_req=1 on that same edge re-sets the latch for the next cycle.
  - walk drops to 0 on exit from S_SG. Extensions keep walk at its current value.
- Safety invariant: main_light and side_light are never both non-RED.
- Parameter values outside their legal range are an elaboration error, raised by an assertion. Value 0 is illegal because the timer would expire immediately.

Decomposition:
- Package tl_pkg contains:
  - the state enum: S_INIT, S_MG, S_MY, S_AR1, S_SG, S_SY, S_AR2;
  - the lamp constants LAMP_RED, LAMP_YEL, LAMP_GRN;
  - the default duration constants.
- Sub-module tl_expiry_detect contains the synchroniser, the rising-edge detect and the armed flag.
  - Inputs: clk, Reset, expired, start_timer.
  - Output: exp_ev.
- The top level holds the FSM, the duration mux, ext_cnt and the walk latch.

Test Plan:
1. Reset low mid-S_SG, then release.
   - Required: lamps go both RED immediately.
   - Then S_AR2 is entered with start_timer=1 for 1 clk and value=1.
   - One expiry later: S_MG with value=10.
2. S_MG, sensor=0, walk_req=0, expiry.
   - Required: main stays GRN; start_timer re-pulses with value=10; no lamp change.
3. S_MG, sensor=1, expiry.
   - Required: state sequence MY(3), AR1(1), SG(6), one phase per expiry.
   - Each transition lands exactly 3 clk after expired rises.
4. S_SG, sensor held 1.
   - Required: two extensions with value=3, then S_SY on the 3rd expiry.
   - ext_cnt resets to 0 at the next S_SG entry.
5. walk_req pulsed 1 clk during S_MG, sensor=0.
   - Required: S_MG then S_MY, and walk=1 throughout S_SG.
   - walk=0 in S_SY; the latch is cleared.
6. expired held high for 50 clk; expiry asserted while not armed.
   - Required: a single transition only.
   - The safety invariant is checked by assertion on every clk of all tests.

Source files
------------

// File: rtl/tl_pkg.sv
// rtl/tl_pkg.sv - shared states, lamp codes and default phase durations
package tl_pkg;

    typedef enum logic [2:0] {
        S_INIT,
        S_MG,
        S_MY,
        S_AR1,
        S_SG,
        S_SY,
        S_AR2
    } tl_state_e;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    localparam logic [3:0] TL_T_MAIN   = 4'd10;
    localparam logic [3:0] TL_T_SIDE   = 4'd6;
    localparam logic [3:0] TL_T_EXT    = 4'd3;
    localparam int         TL_MAX_EXT  = 2;
    localparam logic [3:0] TL_T_YEL    = 4'd3;
    localparam logic [3:0] TL_T_ALLRED = 4'd1;

endpackage

// File: rtl/traffic_light_ctrl_if.sv
// rtl/traffic_light_ctrl_if.sv - handshake between the controller and the phase timer
interface traffic_light_ctrl_if;

    logic [3:0] value;
    logic       start_timer;
    logic       expired;

    modport master (output value, output start_timer, input expired);
    modport slave  (input value, input start_timer, output expired);

endinterface

// File: rtl/tl_expiry_detect.sv
// rtl/tl_expiry_detect.sv - synchronises timer expiry and emits one armed event per phase
module tl_expiry_detect (
    input  logic clk,
    input  logic Reset,
    input  logic expired,
    input  logic start_timer,
    output logic exp_ev
);

    logic sync1;
    logic sync2;
    logic sync2_d;
    logic armed;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync2_d <= 1'b0;
            armed   <= 1'b0;
        end else begin
            sync1   <= expired;
            sync2   <= sync1;
            sync2_d <= sync2;
            // A fresh phase re-arms; the event that ends the phase disarms.
            if (start_timer) begin
                armed <= 1'b1;
            end else if (exp_ev) begin
                armed <= 1'b0;
            end
        end
    end

    assign exp_ev = armed & sync2 & ~sync2_d;

endmodule

// File: rtl/traffic_light_ctrl.sv
// rtl/traffic_light_ctrl.sv - intersection phase sequencer with side-road extensions and walk phase
module traffic_light_ctrl
    import tl_pkg::*;
#(
    parameter logic [3:0] T_MAIN   = TL_T_MAIN,
    parameter logic [3:0] T_SIDE   = TL_T_SIDE,
    parameter logic [3:0] T_EXT    = TL_T_EXT,
    parameter int         MAX_EXT  = TL_MAX_EXT,
    parameter logic [3:0] T_YEL    = TL_T_YEL,
    parameter logic [3:0] T_ALLRED = TL_T_ALLRED
) (
    input  logic                        clk,
    input  logic                        Reset,
    traffic_light_ctrl_if.master        tmr,
    input  logic                        sensor,
    input  logic                        walk_req,
    output logic [2:0]                  main_light,
    output logic [2:0]                  side_light,
    output logic                        walk
);

    // A zero duration would make the timer expire at once.
    if (T_MAIN == 4'd0 || T_SIDE == 4'd0 || T_EXT == 4'd0 || T_YEL == 4'd0 ||
        T_ALLRED == 4'd0 || MAX_EXT < 0 || MAX_EXT > 3) begin : g_param_check
        $error("traffic_light_ctrl: parameter outside legal range");
    end

    localparam logic [1:0] MAX_EXT_L = 2'(MAX_EXT);

    tl_state_e  state_q, state_d;
    logic [3:0] value_q, dur;
    logic       start_q, load, ext_inc, sg_entry, sg_exit, exp_ev, walk_latch;
    logic [1:0] ext_cnt;

    tl_expiry_detect u_expiry_detect (
        .clk         (clk),
        .Reset       (Reset),
        .expired     (tmr.expired),
        .start_timer (start_q),
        .exp_ev      (exp_ev)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        dur     = value_q;
        ext_inc = 1'b0;
        case (state_q)
            S_INIT: begin
                state_d = S_AR2;
                load    = 1'b1;
                dur     = T_ALLRED;
            end
            S_MG: if (exp_ev) begin
                load = 1'b1;
                if (sensor || walk_latch) begin
                    state_d = S_MY;
                    dur     = T_YEL;
                end else begin
                    dur = T_MAIN;
                end
            end
            S_MY: if (exp_ev) begin
                state_d = S_AR1;
                load    = 1'b1;
                dur     = T_ALLRED;
            end
            S_AR1: if (exp_ev) begin
                state_d = S_SG;
                load    = 1'b1;
                dur     = T_SIDE;
            end
            S_SG: if (exp_ev) begin
                load = 1'b1;
                if (sensor && ext_cnt < MAX_EXT_L) begin
                    dur     = T_EXT;
                    ext_inc = 1'b1;
                end else begin
                    state_d = S_SY;
                    dur     = T_YEL;
                end
            end
            S_SY: if (exp_ev) begin
                state_d = S_AR2;
                load    = 1'b1;
                dur     = T_ALLRED;
            end
            S_AR2: if (exp_ev) begin
                state_d = S_MG;
                load    = 1'b1;
                dur     = T_MAIN;
            end
            default: state_d = S_INIT;
        endcase
    end

    assign sg_entry = (state_d == S_SG) && (state_q != S_SG);
    assign sg_exit  = (state_q == S_SG) && (state_d != S_SG);

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= S_INIT;
            value_q    <= 4'd0;
            start_q    <= 1'b0;
            ext_cnt    <= 2'd0;
            walk_latch <= 1'b0;
            walk       <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= load;
            if (load) begin
                value_q <= dur;
            end
            if (sg_entry) begin
                ext_cnt <= 2'd0;
            end else if (ext_inc) begin
                ext_cnt <= ext_cnt + 2'd1;
            end
            // The latch hands its request to the walk lamp on side-green entry.
            if (sg_entry) begin
                walk       <= walk_latch;
                walk_latch <= walk_req;
            end else begin
                if (walk_req && state_q != S_INIT) begin
                    walk_latch <= 1'b1;
                end
                if (sg_exit) begin
                    walk <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        main_light = LAMP_RED;
        side_light = LAMP_RED;
        case (state_q)
            S_MG:    main_light = LAMP_GRN;
            S_MY:    main_light = LAMP_YEL;
            S_SG:    side_light = LAMP_GRN;
            S_SY:    side_light = LAMP_YEL;
            default: ;
        endcase
    end

    assign tmr.value       = value_q;
    assign tmr.start_timer = start_q;

    a_safety: assert property (@(posedge clk) disable iff (!Reset)
        (main_light == LAMP_RED) || (side_light == LAMP_RED));

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb/tb_traffic_light_ctrl.sv - self-checking bench for traffic_light_ctrl
module tb_traffic_light_ctrl;
    import tl_pkg::*;

    typedef struct packed {
        logic       walk_pulse;
        logic       sensor;
        logic [3:0] value;
        logic [2:0] main;
        logic [2:0] side;
        logic       walk;
    } vec_t;

    logic       clk = 1'b0;
    logic       Reset;
    logic       sensor;
    logic       walk_req;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk;

    int   checks   = 0;
    int   failures = 0;
    vec_t exp_q[$];
    vec_t vecs[19];

    traffic_light_ctrl_if tmr();

    traffic_light_ctrl dut (
        .clk        (clk),
        .Reset      (Reset),
        .tmr        (tmr),
        .sensor     (sensor),
        .walk_req   (walk_req),
        .main_light (main_light),
        .side_light (side_light),
        .walk       (walk)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (Reset === 1'b1 && main_light != LAMP_RED && side_light != LAMP_RED) begin
            failures++;
            $display("FAIL safety: main=%b side=%b required one RED", main_light, side_light);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic count_pulses(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (tmr.start_timer) n++;
        end
    endtask

    task automatic do_expiry(input vec_t v);
        int   lat;
        vec_t e;
        if (v.walk_pulse) begin
            @(negedge clk); walk_req = 1'b1;
            @(negedge clk); walk_req = 1'b0;
        end
        exp_q.push_back(v);
        @(negedge clk);
        sensor      = v.sensor;
        tmr.expired = 1'b1;
        lat = 0;
        while (lat < 8) begin
            @(negedge clk);
            lat++;
            if (tmr.start_timer) break;
        end
        check("latency", lat, 3);
        e = exp_q.pop_front();
        check("value", tmr.value, e.value);
        check("main_light", main_light, e.main);
        check("side_light", side_light, e.side);
        check("walk", walk, e.walk);
        @(negedge clk);
        check("start_width", tmr.start_timer, 1'b0);
        tmr.expired = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        vecs[0]  = '{1'b0, 1'b0, 4'd10, LAMP_GRN, LAMP_RED, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 4'd10, LAMP_GRN, LAMP_RED, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 4'd3,  LAMP_YEL, LAMP_RED, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 4'd1,  LAMP_RED, LAMP_RED, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 4'd6,  LAMP_RED, LAMP_GRN, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 4'd3,  LAMP_RED, LAMP_GRN, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 4'd3,  LAMP_RED, LAMP_GRN, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 4'd3,  LAMP_RED, LAMP_YEL, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 4'd1,  LAMP_RED, LAMP_RED, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 4'd10, LAMP_GRN, LAMP_RED, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 4'd3,  LAMP_YEL, LAMP_RED, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 4'd1,  LAMP_RED, LAMP_RED, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 4'd6,  LAMP_RED, LAMP_GRN, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 4'd3,  LAMP_RED, LAMP_GRN, 1'b1};
        vecs[14] = '{1'b0, 1'b1, 4'd3,  LAMP_RED, LAMP_GRN, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 4'd3,  LAMP_RED, LAMP_YEL, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 4'd1,  LAMP_RED, LAMP_RED, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 4'd10, LAMP_GRN, LAMP_RED, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 4'd10, LAMP_GRN, LAMP_RED, 1'b0};

        Reset       = 1'b0;
        sensor      = 1'b0;
        walk_req    = 1'b0;
        tmr.expired = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_main", main_light, LAMP_RED);
        check("rst_side", side_light, LAMP_RED);
        check("rst_walk", walk, 1'b0);
        check("rst_start", tmr.start_timer, 1'b0);
        check("rst_value", tmr.value, 4'd0);

        Reset = 1'b1;
        @(negedge clk);
        check("ar2_start", tmr.start_timer, 1'b1);
        check("ar2_value", tmr.value, 4'd1);
        check("ar2_main", main_light, LAMP_RED);
        @(negedge clk);
        check("ar2_start_width", tmr.start_timer, 1'b0);

        for (int i = 0; i < 19; i++) begin
            do_expiry(vecs[i]);
        end

        // expired held high: exactly one transition MG -> MY
        @(negedge clk);
        sensor      = 1'b1;
        tmr.expired = 1'b1;
        count_pulses(50, n);
        check("held_pulses", n, 1);
        check("held_main", main_light, LAMP_YEL);
        check("held_value", tmr.value, 4'd3);
        tmr.expired = 1'b0;
        repeat (3) @(negedge clk);

        // walk request during MY, then into SG and reset mid-phase
        do_expiry('{1'b1, 1'b0, 4'd1, LAMP_RED, LAMP_RED, 1'b0});
        do_expiry('{1'b0, 1'b0, 4'd6, LAMP_RED, LAMP_GRN, 1'b1});
        repeat (2) @(negedge clk);
        #2 Reset = 1'b0;
        #1;
        check("mid_rst_main", main_light, LAMP_RED);
        check("mid_rst_side", side_light, LAMP_RED);
        check("mid_rst_walk", walk, 1'b0);
        check("mid_rst_value", tmr.value, 4'd0);
        @(negedge clk);
        check("mid_rst_hold_start", tmr.start_timer, 1'b0);
        Reset = 1'b1;
        @(negedge clk);
        check("rel_start", tmr.start_timer, 1'b1);
        check("rel_value", tmr.value, 4'd1);
        @(negedge clk);
        check("rel_start_width", tmr.start_timer, 1'b0);
        do_expiry('{1'b0, 1'b0, 4'd10, LAMP_GRN, LAMP_RED, 1'b0});

        // expired already high across reset release: AR2 entry plus one transition only
        @(negedge clk);
        Reset       = 1'b0;
        sensor      = 1'b0;
        tmr.expired = 1'b1;
        @(negedge clk);
        Reset = 1'b1;
        count_pulses(20, n);
        check("rst_exp_pulses", n, 2);
        check("rst_exp_main", main_light, LAMP_GRN);
        check("rst_exp_value", tmr.value, 4'd10);
        tmr.expired = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
